// File: rtl/icmp_rx_parser.sv
// ICMP echo-request receive parser: checks the ICMP checksum, captures id/seq and
// stores echo data bytes into an external payload RAM.
module icmp_rx_parser #(
  parameter int RAM_AW  = 8,
  parameter int MAX_LEN = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ip_rx_valid,
  input  logic [7:0]        ip_rx_data,
  input  logic              ip_rx_sof,
  input  logic              ip_rx_eof,
  input  logic              ip_rx_is_icmp,
  input  logic              rx_hold,
  output logic              ram_wr_en,
  output logic [RAM_AW-1:0] ram_wr_addr,
  output logic [7:0]        ram_wr_data,
  output logic              rx_done,
  output logic              rx_err,
  output logic [15:0]       rx_id,
  output logic [15:0]       rx_seq,
  output logic [RAM_AW:0]   rx_data_len,
  output logic              busy
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_DROP, S_CHK} state_t;

  localparam logic [RAM_AW:0] MAX_LEN_W = (RAM_AW+1)'(MAX_LEN);

  state_t            state_q, state_d;
  logic [2:0]        hdr_cnt_q, hdr_cnt_d;
  logic              par_q, par_d;
  logic [31:0]       acc_q, acc_d;
  logic [RAM_AW:0]   len_q, len_d;
  logic              ovf_q, ovf_d;
  logic              chk_ph_q, chk_ph_d;
  logic [7:0]        type_q, type_d;
  logic [7:0]        code_q, code_d;
  logic [15:0]       id_tmp_q, id_tmp_d;
  logic [15:0]       seq_tmp_q, seq_tmp_d;
  logic              wr_en_q, wr_en_d;
  logic [RAM_AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [15:0]       rx_id_q, rx_id_d;
  logic [15:0]       rx_seq_q, rx_seq_d;
  logic [RAM_AW:0]   rx_len_q, rx_len_d;

  logic [31:0] byte_word;
  logic [31:0] fold;
  logic        sum_ok;

  // Even byte index is the high half of a 16-bit word; an odd trailing byte is thus zero-padded.
  assign byte_word = par_q ? {24'd0, ip_rx_data} : {16'd0, ip_rx_data, 8'd0};
  assign fold      = {16'd0, acc_q[15:0]} + {16'd0, acc_q[31:16]};
  assign sum_ok    = (fold[15:0] == 16'hFFFF);

  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    par_d     = par_q;
    acc_d     = acc_q;
    len_d     = len_q;
    ovf_d     = ovf_q;
    chk_ph_d  = chk_ph_q;
    type_d    = type_q;
    code_d    = code_q;
    id_tmp_d  = id_tmp_q;
    seq_tmp_d = seq_tmp_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rx_id_d   = rx_id_q;
    rx_seq_d  = rx_seq_q;
    rx_len_d  = rx_len_q;

    if (ip_rx_valid && ip_rx_sof) begin
      // A start byte always restarts parsing, abandoning any frame in flight.
      type_d    = ip_rx_data;
      acc_d     = {16'd0, ip_rx_data, 8'd0};
      par_d     = 1'b1;
      hdr_cnt_d = 3'd1;
      len_d     = '0;
      ovf_d     = 1'b0;
      chk_ph_d  = 1'b0;
      if (ip_rx_is_icmp && !rx_hold) begin
        if (ip_rx_eof) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          state_d = S_HDR;
        end
      end else begin
        state_d = ip_rx_eof ? S_IDLE : S_DROP;
      end
    end else begin
      case (state_q)
        S_HDR: begin
          if (ip_rx_valid) begin
            acc_d     = acc_q + byte_word;
            par_d     = ~par_q;
            hdr_cnt_d = hdr_cnt_q + 3'd1;
            case (hdr_cnt_q)
              3'd1:    code_d = ip_rx_data;
              3'd4:    id_tmp_d[15:8] = ip_rx_data;
              3'd5:    id_tmp_d[7:0] = ip_rx_data;
              3'd6:    seq_tmp_d[15:8] = ip_rx_data;
              3'd7:    seq_tmp_d[7:0] = ip_rx_data;
              default: ;
            endcase
            if (ip_rx_eof) begin
              if (hdr_cnt_q == 3'd7) begin
                state_d = S_CHK;
              end else begin
                state_d = S_IDLE;
                err_d   = 1'b1;
              end
            end else if (hdr_cnt_q == 3'd7) begin
              state_d = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (ip_rx_valid) begin
            acc_d = acc_q + byte_word;
            par_d = ~par_q;
            if (len_q < MAX_LEN_W) begin
              wr_en_d   = 1'b1;
              wr_addr_d = len_q[RAM_AW-1:0];
              wr_data_d = ip_rx_data;
              len_d     = len_q + (RAM_AW+1)'(1);
            end else begin
              ovf_d = 1'b1;
            end
            if (ip_rx_eof) state_d = S_CHK;
          end
        end
        S_DROP: begin
          if (ip_rx_valid && ip_rx_eof) state_d = S_IDLE;
        end
        S_CHK: begin
          if (!chk_ph_q) begin
            acc_d    = fold;
            chk_ph_d = 1'b1;
          end else begin
            state_d  = S_IDLE;
            chk_ph_d = 1'b0;
            if (sum_ok && type_q == 8'd8 && code_q == 8'd0 && !ovf_q) begin
              done_d   = 1'b1;
              rx_id_d  = id_tmp_q;
              rx_seq_d = seq_tmp_q;
              rx_len_d = len_q;
            end else if (!sum_ok || ovf_q) begin
              err_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      hdr_cnt_q <= '0;
      par_q     <= 1'b0;
      acc_q     <= '0;
      len_q     <= '0;
      ovf_q     <= 1'b0;
      chk_ph_q  <= 1'b0;
      type_q    <= '0;
      code_q    <= '0;
      id_tmp_q  <= '0;
      seq_tmp_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rx_id_q   <= '0;
      rx_seq_q  <= '0;
      rx_len_q  <= '0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      par_q     <= par_d;
      acc_q     <= acc_d;
      len_q     <= len_d;
      ovf_q     <= ovf_d;
      chk_ph_q  <= chk_ph_d;
      type_q    <= type_d;
      code_q    <= code_d;
      id_tmp_q  <= id_tmp_d;
      seq_tmp_q <= seq_tmp_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rx_id_q   <= rx_id_d;
      rx_seq_q  <= rx_seq_d;
      rx_len_q  <= rx_len_d;
    end
  end

  assign ram_wr_en   = wr_en_q;
  assign ram_wr_addr = wr_addr_q;
  assign ram_wr_data = wr_data_q;
  assign rx_done     = done_q;
  assign rx_err      = err_q;
  assign rx_id       = rx_id_q;
  assign rx_seq      = rx_seq_q;
  assign rx_data_len = rx_len_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_icmp_rx_parser.sv
// Table-driven bench for icmp_rx_parser: frames are built with a reference ICMP
// checksum, driven byte by byte, and writes/pulses/captured fields are checked.
module tb_icmp_rx_parser;

  localparam int RAM_AW = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ip_rx_valid = 1'b0;
  logic [7:0]        ip_rx_data = '0;
  logic              ip_rx_sof = 1'b0;
  logic              ip_rx_eof = 1'b0;
  logic              ip_rx_is_icmp = 1'b0;
  logic              rx_hold = 1'b0;
  logic              ram_wr_en;
  logic [RAM_AW-1:0] ram_wr_addr;
  logic [7:0]        ram_wr_data;
  logic              rx_done;
  logic              rx_err;
  logic [15:0]       rx_id;
  logic [15:0]       rx_seq;
  logic [RAM_AW:0]   rx_data_len;
  logic              busy;

  icmp_rx_parser #(.RAM_AW(RAM_AW), .MAX_LEN(256)) dut (
    .clk(clk), .rst_n(rst_n), .ip_rx_valid(ip_rx_valid), .ip_rx_data(ip_rx_data),
    .ip_rx_sof(ip_rx_sof), .ip_rx_eof(ip_rx_eof), .ip_rx_is_icmp(ip_rx_is_icmp),
    .rx_hold(rx_hold), .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data), .rx_done(rx_done), .rx_err(rx_err), .rx_id(rx_id),
    .rx_seq(rx_seq), .rx_data_len(rx_data_len), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: counts writes/pulses and verifies address order and data pattern.
  logic [7:0] pat = '0;
  int wr_cnt = 0, wr_bad = 0, wr_last = -1;
  int done_cnt = 0, err_cnt = 0, done_cyc = 0, err_cyc = 0, eof_cyc = 0;

  always @(negedge clk) begin
    if (ram_wr_en) begin
      if (int'(ram_wr_addr) != wr_cnt || ram_wr_data != (ram_wr_addr ^ pat)) wr_bad++;
      wr_last = int'(ram_wr_addr);
      wr_cnt++;
    end
    if (rx_done) begin
      if (done_cnt == 0) done_cyc = cyc;
      done_cnt++;
    end
    if (rx_err) begin
      if (err_cnt == 0) err_cyc = cyc;
      err_cnt++;
    end
  end

  task automatic clr_mon();
    wr_cnt = 0; wr_bad = 0; wr_last = -1;
    done_cnt = 0; err_cnt = 0; done_cyc = 0; err_cyc = 0;
  endtask

  logic [7:0] frame_q[$];

  task automatic build_frame(input logic [7:0] typ, input logic [15:0] id,
                             input logic [15:0] seq, input int len, input bit flip);
    logic [31:0] sum;
    logic [15:0] c;
    frame_q.delete();
    frame_q.push_back(typ);   frame_q.push_back(8'h00);
    frame_q.push_back(8'h00); frame_q.push_back(8'h00);
    frame_q.push_back(id[15:8]);  frame_q.push_back(id[7:0]);
    frame_q.push_back(seq[15:8]); frame_q.push_back(seq[7:0]);
    for (int i = 0; i < len; i++) frame_q.push_back(8'(i) ^ pat);
    sum = 0;
    for (int i = 0; i < frame_q.size(); i++)
      sum += (i % 2 == 0) ? {16'd0, frame_q[i], 8'd0} : {24'd0, frame_q[i]};
    while (sum[31:16] != 0) sum = {16'd0, sum[15:0]} + {16'd0, sum[31:16]};
    c = ~sum[15:0];
    frame_q[2] = flip ? ~c[15:8] : c[15:8];
    frame_q[3] = c[7:0];
  endtask

  // hold_mode: 0 never, 1 on the start byte, 2 on every byte after the start byte.
  task automatic drive_frame(input bit icmp, input int hold_mode, input bit stall,
                             input bit with_eof);
    for (int i = 0; i < frame_q.size(); i++) begin
      if (stall && (i % 5 == 3)) begin
        @(posedge clk); #1;
        ip_rx_valid = 1'b0; ip_rx_sof = 1'b0; ip_rx_eof = 1'b0;
      end
      @(posedge clk); #1;
      ip_rx_valid   = 1'b1;
      ip_rx_data    = frame_q[i];
      ip_rx_sof     = (i == 0);
      ip_rx_eof     = with_eof && (i == frame_q.size() - 1);
      ip_rx_is_icmp = icmp;
      rx_hold       = (hold_mode == 1 && i == 0) || (hold_mode == 2 && i > 0);
      if (ip_rx_eof) eof_cyc = cyc;
    end
    @(posedge clk); #1;
    ip_rx_valid = 1'b0; ip_rx_sof = 1'b0; ip_rx_eof = 1'b0; rx_hold = 1'b0;
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [7:0]  typ;
    logic [15:0] id;
    logic [15:0] seq;
    int          len;
    bit          flip;
    bit          icmp;
    int          hold_mode;
    bit          stall;
    int          exp_wr;
    int          exp_done;
    int          exp_err;
  } vec_t;

  vec_t vecs[11];
  logic [15:0] exp_id = '0, exp_seq = '0;
  int exp_len = 0;

  initial begin
    vecs[0]  = '{"echo32",   8'd8, 16'h1234, 16'h0001, 32,  1'b0, 1'b1, 0, 1'b0, 32,  1, 0};
    vecs[1]  = '{"badcsum",  8'd8, 16'h1234, 16'h0001, 32,  1'b1, 1'b1, 0, 1'b0, 32,  0, 1};
    vecs[2]  = '{"odd33",    8'd8, 16'hBEEF, 16'h0102, 33,  1'b0, 1'b1, 0, 1'b0, 33,  1, 0};
    vecs[3]  = '{"over300",  8'd8, 16'h5555, 16'h0003, 300, 1'b0, 1'b1, 0, 1'b0, 256, 0, 1};
    vecs[4]  = '{"hold",     8'd8, 16'h6666, 16'h0004, 16,  1'b0, 1'b1, 1, 1'b0, 0,   0, 0};
    vecs[5]  = '{"noticmp",  8'd8, 16'h7777, 16'h0005, 16,  1'b0, 1'b0, 0, 1'b0, 0,   0, 0};
    vecs[6]  = '{"reply",    8'd0, 16'h8888, 16'h0006, 4,   1'b0, 1'b1, 0, 1'b0, 4,   0, 0};
    vecs[7]  = '{"len0",     8'd8, 16'h0A0B, 16'h0C0D, 0,   1'b0, 1'b1, 0, 1'b0, 0,   1, 0};
    vecs[8]  = '{"len256",   8'd8, 16'hABCD, 16'h0100, 256, 1'b0, 1'b1, 0, 1'b0, 256, 1, 0};
    vecs[9]  = '{"stall17",  8'd8, 16'h1357, 16'h2468, 17,  1'b0, 1'b1, 0, 1'b1, 17,  1, 0};
    vecs[10] = '{"holdlate", 8'd8, 16'h4242, 16'h0007, 8,   1'b0, 1'b1, 2, 1'b0, 8,   1, 0};

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_wr_en", ram_wr_en, 0);
    check("rst_wr_addr", ram_wr_addr, 0);
    check("rst_wr_data", ram_wr_data, 0);
    check("rst_done", rx_done, 0);
    check("rst_err", rx_err, 0);
    check("rst_busy", busy, 0);
    check("rst_id_seq", {rx_id, rx_seq}, 0);
    check("rst_len", rx_data_len, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int k = 0; k < 11; k++) begin
      pat = 8'(k * 37);
      clr_mon();
      build_frame(vecs[k].typ, vecs[k].id, vecs[k].seq, vecs[k].len, vecs[k].flip);
      drive_frame(vecs[k].icmp, vecs[k].hold_mode, vecs[k].stall, 1'b1);
      settle();
      if (vecs[k].exp_done != 0) begin
        exp_id = vecs[k].id; exp_seq = vecs[k].seq; exp_len = vecs[k].len;
      end
      $display("vec %s: writes=%0d done=%0d err=%0d id=%h seq=%h len=%0d",
               vecs[k].name, wr_cnt, done_cnt, err_cnt, rx_id, rx_seq, rx_data_len);
      check({vecs[k].name, "_writes"}, wr_cnt, vecs[k].exp_wr);
      check({vecs[k].name, "_wr_order_data"}, wr_bad, 0);
      check({vecs[k].name, "_last_addr"}, wr_last, vecs[k].exp_wr - 1);
      check({vecs[k].name, "_done"}, done_cnt, vecs[k].exp_done);
      check({vecs[k].name, "_err"}, err_cnt, vecs[k].exp_err);
      check({vecs[k].name, "_id"}, rx_id, exp_id);
      check({vecs[k].name, "_seq"}, rx_seq, exp_seq);
      check({vecs[k].name, "_len"}, rx_data_len, exp_len);
      check({vecs[k].name, "_idle"}, busy, 0);
      // Pulses land three cycles after the cycle in which the eof byte is presented.
      if (vecs[k].exp_done != 0) check({vecs[k].name, "_done_lat"}, done_cyc - eof_cyc, 3);
      if (vecs[k].exp_err != 0)  check({vecs[k].name, "_err_lat"}, err_cyc - eof_cyc, 3);
    end

    // Truncated header: eof on header byte 4.
    pat = 8'h00;
    clr_mon();
    build_frame(8'd8, 16'h9999, 16'h0009, 0, 1'b0);
    frame_q = frame_q[0:4];
    drive_frame(1'b1, 0, 1'b0, 1'b1);
    settle();
    $display("seq trunc: writes=%0d done=%0d err=%0d", wr_cnt, done_cnt, err_cnt);
    check("trunc_err", err_cnt, 1);
    check("trunc_done", done_cnt, 0);
    check("trunc_writes", wr_cnt, 0);
    check("trunc_id", rx_id, exp_id);

    // New sof in the middle of DATA aborts the first frame.
    clr_mon();
    build_frame(8'd8, 16'h1111, 16'h00AA, 20, 1'b0);
    drive_frame(1'b1, 0, 1'b0, 1'b0);
    build_frame(8'd8, 16'h2222, 16'h00BB, 10, 1'b0);
    drive_frame(1'b1, 0, 1'b0, 1'b1);
    settle();
    $display("seq abort: done=%0d err=%0d id=%h seq=%h len=%0d",
             done_cnt, err_cnt, rx_id, rx_seq, rx_data_len);
    check("abort_done", done_cnt, 1);
    check("abort_err", err_cnt, 0);
    check("abort_id_seq", {rx_id, rx_seq}, 32'h222200BB);
    check("abort_len", rx_data_len, 10);

    // Reset in the middle of DATA abandons the frame.
    clr_mon();
    build_frame(8'd8, 16'h3333, 16'h00CC, 20, 1'b0);
    drive_frame(1'b1, 0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    settle();
    $display("seq reset: done=%0d err=%0d busy=%0d id=%h", done_cnt, err_cnt, busy, rx_id);
    check("rstmid_pulses", done_cnt + err_cnt, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_id", rx_id, 0);
    clr_mon();
    build_frame(8'd8, 16'h4444, 16'h00DD, 12, 1'b0);
    drive_frame(1'b1, 0, 1'b0, 1'b1);
    settle();
    $display("seq after reset: writes=%0d done=%0d id=%h seq=%h", wr_cnt, done_cnt, rx_id, rx_seq);
    check("postrst_done", done_cnt, 1);
    check("postrst_writes", wr_cnt, 12);
    check("postrst_wr_order_data", wr_bad, 0);
    check("postrst_id_seq", {rx_id, rx_seq}, 32'h444400DD);
    check("postrst_done_lat", done_cyc - eof_cyc, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
